// File: rtl/sync_frame_transmitter.sv
// Serial framing transmitter: 1011 sync, W payload bits MSB first, optional even parity
// (SYNC_TX_PARITY_EN), then two zero guard bits. All outputs are registered.
module sync_frame_transmitter #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic                  serial_out,
  output logic                  frame_active,
  output logic                  frame_done
);

  localparam int unsigned CntWidth = $clog2(DATA_WIDTH);
  // Bit k of this constant is the k-th sync bit on the line (1, 0, 1, 1).
  localparam logic [3:0]  SyncBits = 4'b1101;

  typedef enum logic [2:0] {
    StIdle,
    StSync,
    StData,
`ifdef SYNC_TX_PARITY_EN
    StParity,
`endif
    StGuard
  } state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [CntWidth-1:0]   bit_cnt_q;
  logic [1:0]            sync_cnt_q;
  logic                  guard_cnt_q;
`ifdef SYNC_TX_PARITY_EN
  logic                  parity_q;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      sync_cnt_q   <= 2'd0;
      guard_cnt_q  <= 1'b0;
`ifdef SYNC_TX_PARITY_EN
      parity_q     <= 1'b0;
`endif
      serial_out   <= 1'b0;
      data_ready   <= 1'b0;
      frame_active <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (data_valid && data_ready) begin
            shift_q      <= data_in;
`ifdef SYNC_TX_PARITY_EN
            parity_q     <= ^data_in;
`endif
            serial_out   <= SyncBits[0];
            frame_active <= 1'b1;
            data_ready   <= 1'b0;
            sync_cnt_q   <= 2'd1;
            state_q      <= StSync;
          end else begin
            serial_out   <= 1'b0;
            frame_active <= 1'b0;
            data_ready   <= 1'b1;
          end
        end

        StSync: begin
          serial_out <= SyncBits[sync_cnt_q];
          sync_cnt_q <= sync_cnt_q + 2'd1;
          if (sync_cnt_q == 2'd3) begin
            bit_cnt_q <= CntWidth'(DATA_WIDTH - 1);
            state_q   <= StData;
          end
        end

        StData: begin
          serial_out <= shift_q[DATA_WIDTH-1];
          shift_q    <= {shift_q[DATA_WIDTH-2:0], 1'b0};
          bit_cnt_q  <= bit_cnt_q - CntWidth'(1);
          if (bit_cnt_q == '0) begin
            guard_cnt_q <= 1'b0;
`ifdef SYNC_TX_PARITY_EN
            state_q     <= StParity;
`else
            state_q     <= StGuard;
`endif
          end
        end

`ifdef SYNC_TX_PARITY_EN
        StParity: begin
          serial_out  <= parity_q;
          guard_cnt_q <= 1'b0;
          state_q     <= StGuard;
        end
`endif

        StGuard: begin
          serial_out <= 1'b0;
          if (guard_cnt_q) begin
            // Ready rises with the second guard bit so the next word is taken one edge later.
            frame_done <= 1'b1;
            data_ready <= 1'b1;
            state_q    <= StIdle;
          end else begin
            guard_cnt_q <= 1'b1;
          end
        end

        default: begin
          serial_out   <= 1'b0;
          frame_active <= 1'b0;
          data_ready   <= 1'b0;
          state_q      <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sync_frame_transmitter.sv
// Self-checking bench for sync_frame_transmitter: table vectors, hand sequences for
// back-to-back and mid-frame reset, loopback sync counting and randomized frames.
module tb_sync_frame_transmitter;

  localparam int W = 8;
`ifdef SYNC_TX_PARITY_EN
  localparam int Par = 1;
`else
  localparam int Par = 0;
`endif
  localparam int Len = 4 + W + Par + 2;
  localparam logic [31:0] ActMask = (32'd1 << Len) - 32'd1;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         data_valid = 1'b0;
  logic         data_ready;
  logic         serial_out;
  logic         frame_active;
  logic         frame_done;

  sync_frame_transmitter #(.DATA_WIDTH(W)) dut (
    .clock        (clock),
    .reset        (reset),
    .data_in      (data_in),
    .data_valid   (data_valid),
    .data_ready   (data_ready),
    .serial_out   (serial_out),
    .frame_active (frame_active),
    .frame_done   (frame_done)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail = 0;
  int done_pulses = 0;
  int det_hits = 0;
  logic [3:0] det_win = 4'b0000;

  // Line monitor: frame_done pulses and 1011 occurrences seen on the serial line.
  always @(negedge clock) begin
    if (frame_done) done_pulses <= done_pulses + 1;
    if (reset) begin
      det_win <= 4'b0000;
    end else begin
      det_win <= {det_win[2:0], serial_out};
      if ({det_win[2:0], serial_out} == 4'b1011) det_hits <= det_hits + 1;
    end
  end

  typedef struct {
    logic [7:0]  data;
    logic [13:0] frame_np;
    logic [14:0] frame_p;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [15:0] model_frame(input logic [7:0] d);
    logic [15:0] f;
    f = 16'(4'b1011);
    f = (f << 8) | 16'(d);
    if (Par == 1) f = (f << 1) | 16'(^d);
    f = f << 2;
    return f;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int budget = 0;
    while (data_ready !== 1'b1 && budget < 50) begin
      @(negedge clock);
      budget++;
    end
    check("ready_wait", 32'(data_ready), 32'd1);
  endtask

  // Offers d at the current negedge and samples Len line bits; with hold_next the next word
  // is presented during the last bit so it is taken on the very next edge.
  task automatic run_frame(input string name, input logic [7:0] d, input bit hold_next,
                           input logic [7:0] next_d);
    logic [31:0] cap, done_m, act_m, rdy_m;
    logic [15:0] exp;
    cap = '0; done_m = '0; act_m = '0; rdy_m = '0;
    exp = model_frame(d);
    data_in = d;
    data_valid = 1'b1;
    for (int k = 0; k < Len; k++) begin
      @(negedge clock);
      cap    = {cap[30:0], serial_out};
      done_m = {done_m[30:0], frame_done};
      act_m  = {act_m[30:0], frame_active};
      rdy_m  = {rdy_m[30:0], data_ready};
      if (k == Len - 1) begin
        data_valid = hold_next;
        data_in = hold_next ? next_d : 8'($urandom);
      end else begin
        data_valid = hold_next ? 1'b1 : 1'($urandom);
        data_in = 8'($urandom);
      end
    end
    check({name, "_bits"}, cap, 32'(exp));
    check({name, "_active"}, act_m, ActMask);
    check({name, "_done"}, done_m, 32'd1);
    check({name, "_ready"}, rdy_m, 32'd1);
  endtask

  task automatic idle_check(input string name);
    @(negedge clock);
    check(name, 32'({serial_out, frame_active, frame_done, data_ready}), 32'b0001);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] d, nd;
    bit hold, prev_hold;
    int snap;

    vecs[0] = '{8'hA5, 14'b1011_10100101_00, 15'b1011_10100101_0_00};
    vecs[1] = '{8'h07, 14'b1011_00000111_00, 15'b1011_00000111_1_00};
    vecs[2] = '{8'h3C, 14'b1011_00111100_00, 15'b1011_00111100_0_00};
    vecs[3] = '{8'hC3, 14'b1011_11000011_00, 15'b1011_11000011_0_00};
    vecs[4] = '{8'h00, 14'b1011_00000000_00, 15'b1011_00000000_0_00};
    vecs[5] = '{8'hFF, 14'b1011_11111111_00, 15'b1011_11111111_0_00};
    vecs[6] = '{8'h80, 14'b1011_10000000_00, 15'b1011_10000000_1_00};

    // Reset asserted mid-clock: outputs clear at once, ready one edge after release.
    #3 reset = 1'b1;
    #1 check("reset_outputs", 32'({serial_out, frame_active, frame_done, data_ready}), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    check("ready_before_edge", 32'(data_ready), 32'd0);
    @(negedge clock);
    check("ready_after_edge", 32'(data_ready), 32'd1);

    // Table vectors against hand-written expected frames.
    foreach (vecs[i]) begin
      logic [15:0] tbl;
      wait_ready();
      tbl = (Par == 1) ? 16'(vecs[i].frame_p) : 16'(vecs[i].frame_np);
      check("table_model", 32'(model_frame(vecs[i].data)), 32'(tbl));
      run_frame("table", vecs[i].data, 1'b0, 8'h00);
      idle_check("table_idle");
    end

    // Valid held across two words: second accept lands exactly Len+... one frame period later.
    wait_ready();
    run_frame("b2b_first", 8'h3C, 1'b1, 8'hC3);
    run_frame("b2b_second", 8'hC3, 1'b0, 8'h00);
    idle_check("b2b_idle");

    // Reset during data bit 3 (after E8): abort, no frame_done for the partial frame.
    wait_ready();
    snap = done_pulses;
    data_in = 8'h5A;
    data_valid = 1'b1;
    for (int k = 0; k <= 4 + (W - 1 - 3); k++) begin
      @(negedge clock);
      data_valid = 1'b0;
    end
    check("abort_bit3_before", 32'(serial_out), 32'd1);
    #2 reset = 1'b1;
    #1 check("abort_outputs", 32'({serial_out, frame_active, frame_done, data_ready}), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("abort_no_done", 32'(done_pulses - snap), 32'd0);
    wait_ready();
    run_frame("after_abort", 8'h5A, 1'b0, 8'h00);
    idle_check("after_abort_idle");

    // Loopback: three back-to-back zero frames carry exactly three 1011 patterns.
    snap = det_hits;
    wait_ready();
    run_frame("loop1", 8'h00, 1'b1, 8'h00);
    run_frame("loop2", 8'h00, 1'b1, 8'h00);
    run_frame("loop3", 8'h00, 1'b0, 8'h00);
    repeat (3) @(negedge clock);
    check("loopback_syncs", 32'(det_hits - snap), 32'd3);

    // Randomized frames with random idle gaps and random back-to-back holds.
    d = 8'($urandom);
    prev_hold = 1'b0;
    for (int i = 0; i < 20; i++) begin
      nd = 8'($urandom);
      hold = (i < 19) && (($urandom % 2) == 1);
      if (!prev_hold) begin
        repeat ($urandom_range(0, 2)) @(negedge clock);
        wait_ready();
      end
      run_frame("random", d, hold, nd);
      if (!hold) idle_check("random_idle");
      prev_hold = hold;
      d = nd;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
